// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mult_div_unit #(
  parameter int MULT_LATENCY = 5,
  parameter int DIV_LATENCY  = 10
) (
  input  logic        MDU_i_Clk,
  input  logic        MDU_i_nRst,
  input  logic [31:0] MDU_i_Operand1,
  input  logic [31:0] MDU_i_Operand2,
  input  logic [3:0]  MDU_i_Operation,
  input  logic        MDU_i_Start,
  input  logic        MDU_i_Cancel,
  output logic        MDU_o_Busy,
  output logic [31:0] MDU_o_HI,
  output logic [31:0] MDU_o_LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               pend_wr;

  logic               a_neg, b_neg, div_zero;
  logic [31:0]        a_mag, b_mag, s_den, u_den;
  logic [31:0]        sq_mag, sr_mag, sq, sr, uq, ur;
  logic [63:0]        prod_s, prod_u;

  // Low 64 bits of a product are signedness-agnostic once operands are extended.
  always_comb begin
    a_neg    = MDU_i_Operand1[31];
    b_neg    = MDU_i_Operand2[31];
    a_mag    = a_neg ? -MDU_i_Operand1 : MDU_i_Operand1;
    b_mag    = b_neg ? -MDU_i_Operand2 : MDU_i_Operand2;
    div_zero = (MDU_i_Operand2 == 32'd0);
    s_den    = div_zero ? 32'd1 : b_mag;
    u_den    = div_zero ? 32'd1 : MDU_i_Operand2;
    prod_s   = {{32{a_neg}}, MDU_i_Operand1} * {{32{b_neg}}, MDU_i_Operand2};
    prod_u   = {32'd0, MDU_i_Operand1} * {32'd0, MDU_i_Operand2};
    sq_mag   = a_mag / s_den;
    sr_mag   = a_mag % s_den;
    sq       = (a_neg ^ b_neg) ? -sq_mag : sq_mag;
    sr       = a_neg ? -sr_mag : sr_mag;
    uq       = MDU_i_Operand1 / u_den;
    ur       = MDU_i_Operand1 % u_den;
  end

  always_ff @(posedge MDU_i_Clk or negedge MDU_i_nRst) begin
    if (!MDU_i_nRst) begin
      state      <= IDLE;
      count      <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_wr    <= 1'b0;
      MDU_o_Busy <= 1'b0;
      MDU_o_HI   <= '0;
      MDU_o_LO   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MDU_i_Start && !MDU_i_Cancel) begin
            case (MDU_i_Operation)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= (MDU_i_Operation == OP_MULT) ? prod_s : prod_u;
                pend_wr    <= 1'b1;
                count      <= CNT_W'(MULT_LATENCY);
                state      <= BUSY;
                MDU_o_Busy <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi    <= (MDU_i_Operation == OP_DIV) ? sr : ur;
                pend_lo    <= (MDU_i_Operation == OP_DIV) ? sq : uq;
                pend_wr    <= !div_zero;
                count      <= CNT_W'(DIV_LATENCY);
                state      <= BUSY;
                MDU_o_Busy <= 1'b1;
              end
              OP_MTHI: MDU_o_HI <= MDU_i_Operand1;
              OP_MTLO: MDU_o_LO <= MDU_i_Operand1;
              default: ;
            endcase
          end
        end
        BUSY: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            if (pend_wr) begin
              MDU_o_HI <= pend_hi;
              MDU_o_LO <= pend_lo;
            end
            pend_wr    <= 1'b0;
            MDU_o_Busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  opc = '0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  exp_t        sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          busy_cnt = 0;

  mult_div_unit #(.MULT_LATENCY(MLAT), .DIV_LATENCY(DLAT)) dut (
    .MDU_i_Clk(clk),
    .MDU_i_nRst(rst_n),
    .MDU_i_Operand1(op1),
    .MDU_i_Operand2(op2),
    .MDU_i_Operation(opc),
    .MDU_i_Start(start),
    .MDU_i_Cancel(cancel),
    .MDU_o_Busy(busy),
    .MDU_o_HI(hi),
    .MDU_o_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the DUT settles an operation.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy_cnt = 0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hilo", {hi, lo}, 64'd0);
    end else if (busy) begin
      if (busy_cnt == 0 && (sb.size() == 0 || sb[0].lat == 0))
        chk("spurious_busy", 64'(busy), 64'd0);
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (sb.size() > 0) begin
        chk("latency", 64'(busy_cnt), 64'(sb[0].lat));
        chk("hilo_commit", {hi, lo}, {sb[0].hi, sb[0].lo});
        void'(sb.pop_front());
      end
      busy_cnt = 0;
    end else if (sb.size() > 0 && sb[0].lat == 0) begin
      chk("hilo_idle", {hi, lo}, {sb[0].hi, sb[0].lo});
      void'(sb.pop_front());
    end
  end

  task automatic drive_one(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic c);
    @(negedge clk);
    opc = o; op1 = a; op2 = b; start = 1'b1; cancel = c;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic model_push(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic c);
    exp_t e;
    longint sa, sb_v, q, r;
    longint unsigned ua, ub, uqv, urv;
    logic signed [31:0] ta, tb_s;
    ta = a; tb_s = b;
    sa = ta; sb_v = tb_s; ua = a; ub = b;
    e.lat = 0;
    if (!c) begin
      case (o)
        4'd1: begin q = sa * sb_v; {m_hi, m_lo} = q; e.lat = MLAT; end
        4'd2: begin uqv = ua * ub; {m_hi, m_lo} = uqv; e.lat = MLAT; end
        4'd3: begin
          e.lat = DLAT;
          if (b != 0) begin q = sa / sb_v; r = sa % sb_v; m_lo = q[31:0]; m_hi = r[31:0]; end
        end
        4'd4: begin
          e.lat = DLAT;
          if (b != 0) begin uqv = ua / ub; urv = ua % ub; m_lo = uqv[31:0]; m_hi = urv[31:0]; end
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
    e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    drive_one(o, a, b, c);
    model_push(o, a, b, c);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom();
      1: return 32'($urandom_range(0, 20));
      2: return -32'($urandom_range(1, 20));
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h8000_0000;
          1: return 32'hFFFF_FFFF;
          2: return 32'd0;
          default: return 32'h7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    apply(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0); wait_idle();
    apply(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_idle();
    apply(4'd3, -32'd7, 32'd2, 1'b0); wait_idle();
    apply(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_idle();
    apply(4'd5, 32'h11, 32'd0, 1'b0); wait_idle();
    apply(4'd6, 32'h22, 32'd0, 1'b0); wait_idle();
    apply(4'd4, 32'd7, 32'd0, 1'b0); wait_idle();
    apply(4'd3, 32'd5, 32'd0, 1'b0); wait_idle();

    // Starts arriving while busy must be ignored.
    apply(4'd2, 32'd2, 32'd3, 1'b0);
    @(posedge clk);
    drive_one(4'd5, 32'hABCD, 32'd0, 1'b0);
    drive_one(4'd1, 32'd9, 32'd9, 1'b0);
    wait_idle();

    apply(4'd6, 32'h1234, 32'd0, 1'b1); wait_idle();
    apply(4'd6, 32'h1234, 32'd0, 1'b0); wait_idle();
    apply(4'd1, 32'd3, 32'd3, 1'b1); wait_idle();
    apply(4'd9, 32'h5555, 32'h6666, 1'b0); wait_idle();

    // Reset in the middle of a divide aborts it.
    apply(4'd3, 32'd100, 32'd3, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_push(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (12) @(posedge clk);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = pick();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      apply(4'($urandom_range(0, 7)), a, b, ($urandom_range(0, 7) == 0));
      wait_idle();
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
